// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR feedback taps and checker state encoding
package lfsr_pkg;

  localparam int MAX_LENGTH = 9;

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} chk_state_t;

  // Feedback bit for a state right-aligned in MAX_LENGTH bits; full_cycle adds
  // the lock-up term so the all-zero state joins the sequence.
  function automatic logic lfsr_fb(input logic [MAX_LENGTH-1:0] state,
                                   input int length,
                                   input bit full_cycle);
    logic                  fb;
    logic [MAX_LENGTH-1:0] low_mask;
    case (length)
      3:       fb = state[2] ^ state[1];
      4:       fb = state[3] ^ state[2];
      5:       fb = state[4] ^ state[2];
      7:       fb = state[6] ^ state[5];
      8:       fb = state[7] ^ state[5] ^ state[4] ^ state[3];
      9:       fb = state[8] ^ state[4];
      default: fb = state[5] ^ state[4];
    endcase
    low_mask = MAX_LENGTH'((32'd1 << (length - 1)) - 32'd1);
    if (full_cycle) fb = fb ^ ~|(state & low_mask);
    return fb;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational one-step LFSR advance shared by generator and checker
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int LENGTH     = 6,
  parameter int FULL_CYCLE = 1
) (
  input  logic [LENGTH-1:0] state_i,
  output logic [LENGTH-1:0] next_o
);

  logic [MAX_LENGTH-1:0] state_ext;

  assign state_ext = MAX_LENGTH'(state_i);
  assign next_o    = {state_i[LENGTH-2:0], lfsr_fb(state_ext, LENGTH, FULL_CYCLE != 0)};

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR sequence checker with lock and error count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LENGTH      = 6,
  parameter int FULL_CYCLE  = 1,
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 data_valid,
  input  logic [LENGTH-1:0]    data_in,
  input  logic                 clear_count,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [LENGTH-1:0]    expected
);

  // Run counters only need to reach limit-1; reaching the limit is a transition.
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int XW = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

  chk_state_t           state_q, state_d;
  logic [LENGTH-1:0]    exp_q, exp_d;
  logic [MW-1:0]        match_q, match_d;
  logic [XW-1:0]        miss_q, miss_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [LENGTH-1:0]    next_data, next_exp;
  logic                 hit;

  lfsr_step #(.LENGTH(LENGTH), .FULL_CYCLE(FULL_CYCLE)) u_step_data (
    .state_i (data_in),
    .next_o  (next_data)
  );

  lfsr_step #(.LENGTH(LENGTH), .FULL_CYCLE(FULL_CYCLE)) u_step_exp (
    .state_i (exp_q),
    .next_o  (next_exp)
  );

  assign hit = (data_in == exp_q);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= SEED;
      exp_q   <= '1;
      match_q <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (data_valid) begin
      case (state_q)
        SEED: begin
          exp_d   = next_data;
          match_d = '0;
          state_d = HUNT;
        end
        HUNT: begin
          if (hit) begin
            exp_d = next_exp;
            if (match_q == MW'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            exp_d   = next_data;
            match_d = '0;
          end
        end
        LOCKED: begin
          // The reference free-runs here so a single corrupted beat cannot derail it.
          exp_d = next_exp;
          if (!hit) begin
            err_d = 1'b1;
            if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (miss_q == XW'(UNLOCK_ERRS - 1)) begin
              state_d = HUNT;
              exp_d   = next_data;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (clear_count) cnt_d = '0;
  end

  assign locked    = (state_q == LOCKED);
  assign error     = err_q;
  assign err_count = cnt_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker, two configurations
module tb_lfsr_checker;

  localparam int LC = 4;
  localparam int UE = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dv [2];
  logic [5:0] din [2];
  logic       clr [2];
  logic       lk [2];
  logic       er [2];
  logic [5:0] ex [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  // staged inputs for the next cycle
  logic       srst;
  logic       sv [2];
  logic [5:0] sd [2];
  logic       sc [2];

  int tests = 0;
  int fails = 0;

  // reference model state per instance
  int m_mode [2];
  int m_exp [2];
  int m_run [2];
  int m_miss [2];
  int m_cnt [2];
  int m_err [2];
  int fc_of [2];
  int cmax_of [2];
  logic [5:0] gs [2];

  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  always #5 clock = ~clock;

  lfsr_checker #(.LENGTH(6), .FULL_CYCLE(1), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .CNT_WIDTH(16)) dut_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_valid  (dv[0]),
    .data_in     (din[0]),
    .clear_count (clr[0]),
    .locked      (lk[0]),
    .error       (er[0]),
    .err_count   (cnt0),
    .expected    (ex[0])
  );

  lfsr_checker #(.LENGTH(6), .FULL_CYCLE(0), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .CNT_WIDTH(2)) dut_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_valid  (dv[1]),
    .data_in     (din[1]),
    .clear_count (clr[1]),
    .locked      (lk[1]),
    .error       (er[1]),
    .err_count   (cnt1),
    .expected    (ex[1])
  );

  // Sequence rule as arithmetic: shift left, append tap xor (+ lock-up term).
  function automatic logic [5:0] gn(input logic [5:0] s, input int fc);
    int v;
    int fb;
    v  = int'(s);
    fb = ((v >> 5) & 1) ^ ((v >> 4) & 1);
    if (fc != 0 && (v % 32) == 0) fb = fb ^ 1;
    return 6'(((v * 2) % 64) + fb);
  endfunction

  function automatic logic [23:0] model(input int i, input bit rst, input bit v,
                                        input logic [5:0] d, input bit c);
    int cur;
    if (rst) begin
      m_mode[i] = 0; m_exp[i] = 63; m_run[i] = 0; m_miss[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
    end else begin
      m_err[i] = 0;
      cur = m_exp[i];
      if (v) begin
        if (m_mode[i] == 0) begin
          m_exp[i] = int'(gn(d, fc_of[i])); m_run[i] = 0; m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
          if (int'(d) == cur) begin
            m_run[i]++;
            m_exp[i] = int'(gn(6'(cur), fc_of[i]));
            if (m_run[i] == LC) begin m_mode[i] = 2; m_run[i] = 0; m_miss[i] = 0; end
          end else begin
            m_exp[i] = int'(gn(d, fc_of[i])); m_run[i] = 0;
          end
        end else begin
          m_exp[i] = int'(gn(6'(cur), fc_of[i]));
          if (int'(d) != cur) begin
            m_err[i] = 1;
            if (m_cnt[i] < cmax_of[i]) m_cnt[i]++;
            m_miss[i]++;
            if (m_miss[i] == UE) begin
              m_mode[i] = 1; m_exp[i] = int'(gn(d, fc_of[i])); m_run[i] = 0; m_miss[i] = 0;
            end
          end else begin
            m_miss[i] = 0;
          end
        end
      end
      if (c) m_cnt[i] = 0;
    end
    return {m_mode[i] == 2, m_err[i] == 1, 16'(m_cnt[i]), 6'(m_exp[i])};
  endfunction

  task automatic cycle();
    @(negedge clock);
    reset_n = srst;
    for (int i = 0; i < 2; i++) begin
      dv[i] = sv[i]; din[i] = sd[i]; clr[i] = sc[i];
    end
    q0.push_back(model(0, !srst, sv[0], sd[0], sc[0]));
    q1.push_back(model(1, !srst, sv[1], sd[1], sc[1]));
    @(posedge clock);
    #2;
  endtask

  task automatic idle_stage();
    srst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sd[i] = 6'($urandom_range(0, 63)); sc[i] = 1'b0;
    end
  endtask

  task automatic beat(input int i, input bit v, input logic [5:0] d, input bit c);
    idle_stage();
    sv[i] = v; sd[i] = d; sc[i] = c;
    cycle();
  endtask

  task automatic good(input int i);
    beat(i, 1'b1, gs[i], 1'b0);
    gs[i] = gn(gs[i], fc_of[i]);
  endtask

  task automatic bad(input int i, input bit c);
    beat(i, 1'b1, gs[i] ^ 6'h01, c);
    gs[i] = gn(gs[i], fc_of[i]);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      idle_stage();
      srst = 1'b0;
      cycle();
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  initial begin
    logic [23:0] e;
    logic [23:0] a;
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = {lk[0], er[0], cnt0, ex[0]};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL sb_a: got lk=%0b er=%0b cnt=%0h exp=%0h expected lk=%0b er=%0b cnt=%0h exp=%0h",
                   a[23], a[22], a[21:6], a[5:0], e[23], e[22], e[21:6], e[5:0]);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {lk[1], er[1], 14'd0, cnt1, ex[1]};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL sb_b: got lk=%0b er=%0b cnt=%0h exp=%0h expected lk=%0b er=%0b cnt=%0h exp=%0h",
                   a[23], a[22], a[21:6], a[5:0], e[23], e[22], e[21:6], e[5:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int burst [2];
    bit v;
    bit b;
    fc_of[0] = 1; fc_of[1] = 0;
    cmax_of[0] = 65535; cmax_of[1] = 3;
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; din[i] = '0; clr[i] = 1'b0; gs[i] = 6'h3F; burst[i] = 0;
    end

    do_reset(2);
    chk("reset_locked", int'(lk[0]), 0);
    chk("reset_expected", int'(ex[0]), 'h3F);
    chk("reset_count", int'(cnt0), 0);

    // clean lock: 3F,3E,3C,38,30
    for (int k = 0; k < 5; k++) begin
      if (k == 3) chk("lock_not_early", int'(lk[0]), 0);
      good(0);
    end
    chk("lock_after_5", int'(lk[0]), 1);
    chk("clean_count", int'(cnt0), 0);

    // lock-up wrap 20 -> 00 -> 01
    chk("wrap_word", int'(gs[0]), 'h20);
    good(0);
    good(0);
    chk("wrap_zero_noerr", int'(er[0]), 0);
    chk("wrap_zero_next", int'(ex[0]), 'h01);
    good(0);
    chk("wrap_one_noerr", int'(er[0]), 0);
    chk("wrap_one_next", int'(ex[0]), 'h02);

    // single bit flip
    good(0);
    bad(0, 1'b0);
    chk("flip_error", int'(er[0]), 1);
    chk("flip_count", int'(cnt0), 1);
    chk("flip_locked", int'(lk[0]), 1);
    good(0);
    chk("flip_recover", int'(er[0]), 0);
    chk("flip_recover_lock", int'(lk[0]), 1);

    // loss of lock
    for (int k = 0; k < UE; k++) begin
      bad(0, 1'b0);
      chk("unlock_err_pulse", int'(er[0]), 1);
      if (k < UE - 1) chk("unlock_still_locked", int'(lk[0]), 1);
    end
    chk("unlock_fall", int'(lk[0]), 0);
    chk("unlock_count", int'(cnt0), 5);
    for (int k = 0; k < 5; k++) good(0);
    chk("relock", int'(lk[0]), 1);

    // FULL_CYCLE=0 instance: 3F -> 3E and period 63
    beat(1, 1'b1, 6'h3F, 1'b0);
    gs[1] = gn(6'h3F, 0);
    chk("nfc_seed_next", int'(ex[1]), 'h3E);
    for (int k = 0; k < 62; k++) good(1);
    chk("nfc_period", int'(ex[1]), 'h3F);
    chk("nfc_locked", int'(lk[1]), 1);

    // saturation on 2-bit counter, then clear racing an error
    for (int k = 0; k < 5; k++) begin
      bad(1, 1'b0);
      good(1);
    end
    chk("sat_count", int'(cnt1), 3);
    bad(1, 1'b1);
    chk("clear_wins", int'(cnt1), 0);
    chk("clear_err_pulse", int'(er[1]), 1);

    // reset mid-operation, then lock across valid gaps
    do_reset(1);
    chk("mid_reset_locked", int'(lk[0]), 0);
    chk("mid_reset_expected", int'(ex[0]), 'h3F);
    chk("mid_reset_count", int'(cnt0), 0);
    for (int k = 0; k < 5; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) beat(0, 1'b0, 6'($urandom), 1'b0);
      if (k == 4) chk("gap_not_early", int'(lk[0]), 0);
      good(0);
    end
    chk("gap_lock", int'(lk[0]), 1);

    // randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      srst = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < 2; i++) begin
        v = ($urandom_range(0, 9) < 7);
        if (burst[i] == 0 && $urandom_range(0, 39) == 0) burst[i] = $urandom_range(1, 6);
        b = v && (burst[i] > 0);
        if (b) burst[i]--;
        sv[i] = v;
        sd[i] = v ? (b ? gs[i] ^ 6'($urandom_range(1, 63)) : gs[i]) : 6'($urandom);
        sc[i] = ($urandom_range(0, 49) == 0);
        if (v) gs[i] = gn(gs[i], fc_of[i]);
      end
      cycle();
    end

    idle_stage();
    cycle();
    @(posedge clock);
    #3;
    chk("sb_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
